// File: rtl/hall_input_filter.sv
// ============================================================================
// Module   : hall_input_filter
// Purpose  : Conditions the three raw Hall pins {C,B,A} for the three-phase
//            encoder: two-flop synchroniser per bit, a shared stability
//            filter, legal-sequence tracking, glitch counting, skipped-sector
//            detection and a sticky fault for persistent illegal codes.
// Options  : HALL_SKIP_REJECT_EN - when defined, a stable non-adjacent code is
//            held off (skip_error only) and force-accepted once it has stayed
//            stable for REJECT_TICKS cycles.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hall_input_filter #(
  parameter int CLK_FREQ_HZ  = 27_000_000,
  parameter int FILTER_TICKS = 27,
  parameter int FAULT_TICKS  = 270_000,
  parameter int REJECT_TICKS = 108,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             i_hall_raw,
  input  logic                   i_fault_clear,
  output logic [2:0]             o_hall_values,
  output logic                   o_hall_valid,
  output logic                   o_edge_pulse,
  output logic                   o_skip_error,
  output logic                   o_invalid_fault,
  output logic [COUNT_WIDTH-1:0] o_glitch_count
);

  // Stability counter saturates where the last decision on a candidate is made.
`ifdef HALL_SKIP_REJECT_EN
  localparam int c_CNT_MAX = REJECT_TICKS;
`else
  localparam int c_CNT_MAX = FILTER_TICKS;
`endif
  localparam int c_CNT_W = $clog2(c_CNT_MAX + 1);
  localparam int c_FLT_W = $clog2(FAULT_TICKS + 1);

  // Elaboration-time parameter sanity checks.
  if (CLK_FREQ_HZ < 1) begin : g_chk_clk
    $error("hall_input_filter: CLK_FREQ_HZ must be positive");
  end
  if (FILTER_TICKS < 1) begin : g_chk_filter
    $error("hall_input_filter: FILTER_TICKS must be at least 1");
  end
  if (FAULT_TICKS < 1) begin : g_chk_fault
    $error("hall_input_filter: FAULT_TICKS must be at least 1");
  end
  if (COUNT_WIDTH < 1) begin : g_chk_count
    $error("hall_input_filter: COUNT_WIDTH must be at least 1");
  end
`ifdef HALL_SKIP_REJECT_EN
  if (REJECT_TICKS <= FILTER_TICKS) begin : g_chk_reject
    $error("hall_input_filter: REJECT_TICKS must exceed FILTER_TICKS");
  end
`else
  if (REJECT_TICKS < 0) begin : g_chk_reject
    $error("hall_input_filter: REJECT_TICKS must not be negative");
  end
`endif

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_INVALID = 2'd2
  } state_t;

  // 000 and 111 can never be produced by healthy sensors.
  function automatic logic f_legal(input logic [2:0] code);
    return (code != 3'b000) && (code != 3'b111);
  endfunction

  // Neighbouring sectors in the legal sequence differ in exactly one bit.
  function automatic logic f_adjacent(input logic [2:0] a, input logic [2:0] b);
    return $onehot(a ^ b);
  endfunction

  logic [2:0]             r_sync1;
  logic [2:0]             r_sync2;
  logic [2:0]             r_cand;
  logic [c_CNT_W-1:0]     r_stab_cnt;
  logic [COUNT_WIDTH-1:0] r_glitch_cnt;
  state_t                 r_state;
  logic [2:0]             r_hall_values;
  logic                   r_hall_valid;
  logic                   r_edge_pulse;
  logic                   r_skip_error;
  logic                   r_held;
  logic [c_FLT_W-1:0]     r_fault_cnt;
  logic                   r_invalid_fault;

  logic                   w_change;
  logic                   w_stable;
  logic                   w_glitch;
  logic                   w_legal;
  logic                   w_adjacent;
  logic                   w_new_code;
  state_t                 w_state_nxt;
  logic [2:0]             w_hall_nxt;
  logic                   w_valid_nxt;
  logic                   w_edge_nxt;
  logic                   w_skip_nxt;
  logic                   w_held_nxt;
  logic [c_FLT_W-1:0]     w_fault_cnt_nxt;
  logic                   w_fault_set;
`ifdef HALL_SKIP_REJECT_EN
  logic                   w_force;
`endif

  // Candidate events: a new sync value restarts the filter; the stable event
  // fires in the single cycle where the counter reaches FILTER_TICKS.
  assign w_change   = (r_sync2 != r_cand);
  assign w_stable   = !w_change && (r_stab_cnt == c_CNT_W'(FILTER_TICKS - 1));
  assign w_glitch   = w_change && (r_stab_cnt < c_CNT_W'(FILTER_TICKS))
                      && (r_cand != r_hall_values);
  assign w_legal    = f_legal(r_sync2);
  assign w_adjacent = f_adjacent(r_sync2, r_hall_values);
  assign w_new_code = (r_sync2 != r_hall_values);
`ifdef HALL_SKIP_REJECT_EN
  assign w_force    = !w_change && (r_stab_cnt == c_CNT_W'(REJECT_TICKS - 1));
`endif

  // Two-flop synchroniser for the asynchronous Hall pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= i_hall_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Stability filter: track the candidate and how long it has been steady.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand     <= 3'b000;
      r_stab_cnt <= '0;
    end else if (w_change) begin
      r_cand     <= r_sync2;
      r_stab_cnt <= '0;
    end else if (r_stab_cnt != c_CNT_W'(c_CNT_MAX)) begin
      r_stab_cnt <= r_stab_cnt + 1'b1;
    end
  end

  // Saturating count of candidates abandoned before they became stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch && (r_glitch_cnt != '1)) begin
      r_glitch_cnt <= r_glitch_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and output decisions driven by stable-code events.
  always_comb begin
    w_state_nxt     = r_state;
    w_hall_nxt      = r_hall_values;
    w_valid_nxt     = r_hall_valid;
    w_edge_nxt      = 1'b0;
    w_skip_nxt      = 1'b0;
    w_held_nxt      = r_held;
    w_fault_cnt_nxt = r_fault_cnt;
    w_fault_set     = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (w_stable) begin
          if (w_legal) begin
            w_hall_nxt  = r_sync2;
            w_valid_nxt = 1'b1;
            w_held_nxt  = 1'b1;
            w_state_nxt = ST_TRACK;
          end else begin
            w_fault_cnt_nxt = '0;
            w_state_nxt     = ST_INVALID;
          end
        end
      end
      ST_TRACK: begin
        if (w_stable) begin
          if (!w_legal) begin
            w_valid_nxt     = 1'b0;
            w_fault_cnt_nxt = '0;
            w_state_nxt     = ST_INVALID;
          end else if (w_new_code) begin
            if (w_adjacent) begin
              w_hall_nxt = r_sync2;
              w_edge_nxt = 1'b1;
            end else begin
              w_skip_nxt = 1'b1;
`ifndef HALL_SKIP_REJECT_EN
              w_hall_nxt = r_sync2;
              w_edge_nxt = 1'b1;
`endif
            end
          end
        end
`ifdef HALL_SKIP_REJECT_EN
        // A rejected code that persists is taken as a missed edge.
        else if (w_force && w_legal && w_new_code && !w_adjacent) begin
          w_hall_nxt = r_sync2;
          w_edge_nxt = 1'b1;
        end
`endif
      end
      ST_INVALID: begin
        if (w_change) begin
          w_fault_cnt_nxt = '0;
        end else if (r_fault_cnt != c_FLT_W'(FAULT_TICKS)) begin
          w_fault_cnt_nxt = r_fault_cnt + 1'b1;
          w_fault_set     = (r_fault_cnt == c_FLT_W'(FAULT_TICKS - 1));
        end
        if (w_stable && w_legal) begin
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_TRACK;
          if (!r_held) begin
            w_hall_nxt = r_sync2;
            w_held_nxt = 1'b1;
          end else if (w_new_code) begin
            w_hall_nxt = r_sync2;
            w_edge_nxt = 1'b1;
            w_skip_nxt = !w_adjacent;
          end
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // Registered outputs and fault bookkeeping; a new fault beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hall_values   <= 3'b000;
      r_hall_valid    <= 1'b0;
      r_edge_pulse    <= 1'b0;
      r_skip_error    <= 1'b0;
      r_held          <= 1'b0;
      r_fault_cnt     <= '0;
      r_invalid_fault <= 1'b0;
    end else begin
      r_hall_values <= w_hall_nxt;
      r_hall_valid  <= w_valid_nxt;
      r_edge_pulse  <= w_edge_nxt;
      r_skip_error  <= w_skip_nxt;
      r_held        <= w_held_nxt;
      r_fault_cnt   <= w_fault_cnt_nxt;
      if (w_fault_set) begin
        r_invalid_fault <= 1'b1;
      end else if (i_fault_clear) begin
        r_invalid_fault <= 1'b0;
      end
    end
  end

  assign o_hall_values   = r_hall_values;
  assign o_hall_valid    = r_hall_valid;
  assign o_edge_pulse    = r_edge_pulse;
  assign o_skip_error    = r_skip_error;
  assign o_invalid_fault = r_invalid_fault;
  assign o_glitch_count  = r_glitch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hall_input_filter.sv
// ============================================================================
// Module   : tb_hall_input_filter
// Purpose  : Self-checking bench for hall_input_filter. A reference model
//            reasons about runs of synchronised samples and pushes expected
//            pulses into a scoreboard; a monitor pops them when the DUT pulses
//            and also compares the level outputs every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hall_input_filter;

  localparam int P_FILTER = 4;
  localparam int P_FAULT  = 20;
  localparam int P_REJECT = 12;
  localparam int P_CW     = 3;
  localparam int GMAX     = (1 << P_CW) - 1;

  localparam int M_INIT    = 0;
  localparam int M_TRACK   = 1;
  localparam int M_INVALID = 2;

  logic            clk         = 1'b0;
  logic            reset       = 1'b1;
  logic [2:0]      hall_raw    = 3'b000;
  logic            fault_clear = 1'b0;
  logic [2:0]      hall_values;
  logic            hall_valid;
  logic            edge_pulse;
  logic            skip_error;
  logic            invalid_fault;
  logic [P_CW-1:0] glitch_count;

  always #5 clk = ~clk;

  hall_input_filter #(
    .CLK_FREQ_HZ  (27_000_000),
    .FILTER_TICKS (P_FILTER),
    .FAULT_TICKS  (P_FAULT),
    .REJECT_TICKS (P_REJECT),
    .COUNT_WIDTH  (P_CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_hall_raw      (hall_raw),
    .i_fault_clear   (fault_clear),
    .o_hall_values   (hall_values),
    .o_hall_valid    (hall_valid),
    .o_edge_pulse    (edge_pulse),
    .o_skip_error    (skip_error),
    .o_invalid_fault (invalid_fault),
    .o_glitch_count  (glitch_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit started = 1'b0;

  typedef struct {
    int cyc;
    bit edge_p;
    bit skip_p;
  } ev_t;
  ev_t sb[$];

  logic [2:0] seq [6] = '{3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int f_pos(input logic [2:0] c);
    for (int i = 0; i < 6; i++) if (seq[i] == c) return i;
    return -1;
  endfunction

  function automatic bit f_adj(input logic [2:0] a, input logic [2:0] b);
    int d;
    d = (f_pos(a) - f_pos(b) + 6) % 6;
    return (d == 1) || (d == 5);
  endfunction

  // Reference model state
  int         m_state;
  logic [2:0] m_hv;
  bit         m_valid, m_fault, m_held;
  int         m_glitch;
  logic [2:0] dly0, dly1, run_code;
  int         run_len, run_start, inv_entry;

  task automatic push_ev(input bit e, input bit s);
    ev_t ev;
    ev.cyc = cyc; ev.edge_p = e; ev.skip_p = s;
    sb.push_back(ev);
  endtask

  // Model: a code is stable when the synchronised stream (raw delayed two
  // samples) has held it for FILTER+1 consecutive samples.
  always @(posedge clk) begin
    logic [2:0] d;
    bit fset, legal;
    int ref_t;
    cyc++;
    if (reset) begin
      started = 1'b1;
      m_state = M_INIT; m_hv = 3'b000; m_valid = 0; m_fault = 0; m_held = 0;
      m_glitch = 0;
      dly0 = 3'b000; dly1 = 3'b000; run_code = 3'b000;
      run_len = 1; run_start = cyc; inv_entry = cyc;
    end else if (started) begin
      d = dly0; dly0 = dly1; dly1 = hall_raw;
      if (d != run_code) begin
        if (run_len <= P_FILTER && run_code != m_hv && m_glitch < GMAX) m_glitch++;
        run_code = d; run_len = 1; run_start = cyc;
      end else begin
        run_len++;
      end
      fset = 0;
      if (m_state == M_INVALID) begin
        ref_t = (run_start > inv_entry) ? run_start : inv_entry;
        if (cyc - ref_t == P_FAULT) fset = 1;
      end
      legal = (f_pos(d) >= 0);
      if (run_len == P_FILTER + 1) begin
        if (m_state == M_INIT) begin
          if (legal) begin m_hv = d; m_valid = 1; m_held = 1; m_state = M_TRACK; end
          else begin m_state = M_INVALID; inv_entry = cyc; end
        end else if (m_state == M_TRACK) begin
          if (!legal) begin m_valid = 0; m_state = M_INVALID; inv_entry = cyc; end
          else if (d != m_hv) begin
            if (f_adj(d, m_hv)) begin push_ev(1, 0); m_hv = d; end
            else begin
`ifdef HALL_SKIP_REJECT_EN
              push_ev(0, 1);
`else
              push_ev(1, 1); m_hv = d;
`endif
            end
          end
        end else begin
          if (legal) begin
            m_valid = 1; m_state = M_TRACK;
            if (!m_held) begin m_hv = d; m_held = 1; end
            else if (d != m_hv) begin push_ev(1, !f_adj(d, m_hv)); m_hv = d; end
          end
        end
      end
`ifdef HALL_SKIP_REJECT_EN
      else if (run_len == P_REJECT + 1 && m_state == M_TRACK && legal &&
               d != m_hv && !f_adj(d, m_hv)) begin
        push_ev(1, 0); m_hv = d;
      end
`endif
      if (fset) m_fault = 1;
      else if (fault_clear) m_fault = 0;
    end
  end

  // Monitor: level outputs every cycle, pulses against the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (started) begin
      check("hall_values", hall_values, m_hv);
      check("hall_valid", hall_valid, m_valid);
      check("invalid_fault", invalid_fault, m_fault);
      check("glitch_count", glitch_count, m_glitch);
      if (edge_pulse || skip_error) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {edge_pulse, skip_error}, 0);
        end else begin
          e = sb.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("edge_pulse", edge_pulse, e.edge_p);
          check("skip_error", skip_error, e.skip_p);
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        check("missing_edge_pulse", edge_pulse, e.edge_p);
        check("missing_skip_error", skip_error, e.skip_p);
      end
    end
  end

  initial begin
    logic [2:0] code, last;
    int len, p, r;
    repeat (3) @(negedge clk);

    // Acquisition after reset: valid on edge 7, no edge pulse
    reset = 0; hall_raw = 3'b001;
    repeat (6) @(posedge clk); #1;
    check("acq_valid_early", hall_valid, 0);
    @(posedge clk); #1;
    check("acq_valid", hall_valid, 1);
    check("acq_values", hall_values, 3'b001);
    check("acq_no_edge", edge_pulse, 0);
    check("acq_glitch", glitch_count, 0);
    repeat (5) @(negedge clk);

    // Adjacent step 001 -> 011
    hall_raw = 3'b011;
    repeat (6) @(posedge clk); #1;
    check("step_edge_early", edge_pulse, 0);
    @(posedge clk); #1;
    check("step_edge", edge_pulse, 1);
    check("step_values", hall_values, 3'b011);
    check("step_skip", skip_error, 0);
    @(posedge clk); #1;
    check("step_edge_width", edge_pulse, 0);
    repeat (3) @(negedge clk);

    // Two-cycle glitch to 010
    hall_raw = 3'b010;
    repeat (2) @(negedge clk);
    hall_raw = 3'b011;
    repeat (12) @(posedge clk); #1;
    check("glitch_values", hall_values, 3'b011);
    check("glitch_count1", glitch_count, 1);

    // Persistent illegal 111
    @(negedge clk); hall_raw = 3'b111;
    repeat (6) @(posedge clk); #1;
    check("ill_valid_early", hall_valid, 1);
    @(posedge clk); #1;
    check("ill_valid", hall_valid, 0);
    check("ill_values_held", hall_values, 3'b011);
    repeat (19) @(posedge clk); #1;
    check("fault_early", invalid_fault, 0);
    @(posedge clk); #1;
    check("fault_set", invalid_fault, 1);
    repeat (3) @(posedge clk);
    @(negedge clk); hall_raw = 3'b011;
    repeat (12) @(posedge clk); #1;
    check("recover_valid", hall_valid, 1);
    check("recover_values", hall_values, 3'b011);
    check("fault_sticky", invalid_fault, 1);
    @(negedge clk); fault_clear = 1;
    @(negedge clk); fault_clear = 0; #1;
    check("fault_cleared", invalid_fault, 0);

    // Non-adjacent step 001 -> 010
    hall_raw = 3'b001;
    repeat (10) @(posedge clk);
    @(negedge clk); hall_raw = 3'b010;
    repeat (6) @(posedge clk); #1;
    check("skip_early", skip_error, 0);
    @(posedge clk); #1;
    check("skip_pulse", skip_error, 1);
`ifdef HALL_SKIP_REJECT_EN
    check("skip_no_edge", edge_pulse, 0);
    check("skip_held", hall_values, 3'b001);
    repeat (7) @(posedge clk); #1;
    check("force_early", edge_pulse, 0);
    @(posedge clk); #1;
    check("force_edge", edge_pulse, 1);
    check("force_values", hall_values, 3'b010);
    check("force_no_skip", skip_error, 0);
`else
    check("skip_edge", edge_pulse, 1);
    check("skip_values", hall_values, 3'b010);
`endif
    repeat (4) @(negedge clk);

    // Reset mid-filter on 010 -> 011
    hall_raw = 3'b011;
    repeat (5) @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    check("rst_values", hall_values, 0);
    check("rst_valid", hall_valid, 0);
    check("rst_edge", edge_pulse, 0);
    check("rst_glitch", glitch_count, 0);
    @(negedge clk); reset = 0;
    repeat (6) @(posedge clk); #1;
    check("reacq_valid_early", hall_valid, 0);
    @(posedge clk); #1;
    check("reacq_valid", hall_valid, 1);
    check("reacq_values", hall_values, 3'b011);
    check("reacq_no_edge", edge_pulse, 0);

    // Randomised segments
    last = 3'b011;
    for (int s = 0; s < 300; s++) begin
      r = $urandom_range(0, 99);
      p = f_pos(last);
      if (p < 0) p = $urandom_range(0, 5);
      if (r < 55)      code = seq[($urandom_range(0, 1) == 0) ? (p + 1) % 6 : (p + 5) % 6];
      else if (r < 70) code = seq[(p + $urandom_range(2, 4)) % 6];
      else if (r < 82) code = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
      else             code = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) len = $urandom_range(1, P_FILTER);
      else                           len = $urandom_range(P_FILTER + 1, P_REJECT + 6);
      if (f_pos(code) < 0 && $urandom_range(0, 2) == 0) len = P_FAULT + $urandom_range(5, 12);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        if (i == 0) hall_raw = code;
        fault_clear = ($urandom_range(0, 19) == 0);
        reset       = ($urandom_range(0, 299) == 0);
      end
      if (f_pos(code) >= 0) last = code;
    end
    @(negedge clk); reset = 0; fault_clear = 0;
    repeat (30) @(posedge clk); #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
